// File: rtl/pika_pkg.sv
// Shared PikaRISC decode definitions: RV32I opcodes, immediate formats and the
// registered control/field bundle handed from decode to execute.
package pika_pkg;

    localparam int unsigned OPC_W   = 7;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned F7_W    = 7;
    localparam int unsigned INSTR_W = 32;

    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [F3_W-1:0]  funct3;
        logic [F7_W-1:0]  funct7;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             rd_we;
        logic             mem_rd;
        logic             mem_wr;
        logic             is_branch;
        logic             is_jump;
        logic             illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator: picks the RV32I format from the opcode and
// produces the sign-extended immediate (zero for formats without one).
module imm_gen
    import pika_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr,
    output imm_fmt_e           fmt_c,
    output logic [XLEN-1:0]    imm_c
);

    logic [INSTR_W-1:0] imm32;

    // Format select; anything not listed (including OP) carries no immediate.
    always_comb begin
        fmt_c = IMM_NONE;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC:                         fmt_c = IMM_U;
            OPC_JAL:                                    fmt_c = IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_SYSTEM:  fmt_c = IMM_I;
            OPC_BRANCH:                                 fmt_c = IMM_B;
            OPC_STORE:                                  fmt_c = IMM_S;
            default:                                    fmt_c = IMM_NONE;
        endcase
    end

    always_comb begin
        imm32 = '0;
        case (fmt_c)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_c = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/decode.sv
// PikaRISC RV32I decode stage: field/flag decode of the fetched instruction into
// an output register backed by a one-entry skid buffer toward execute.
module decode
    import pika_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PCW  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PCW-1:0]     pc_in,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic               flush,
    output logic               valid_out,
    input  logic               ready_in,
    output logic [PCW-1:0]     pc_out,
    output logic [OPC_W-1:0]   opcode,
    output logic [F3_W-1:0]    funct3,
    output logic [F7_W-1:0]    funct7,
    output logic [REG_W-1:0]   rd,
    output logic [REG_W-1:0]   rs1,
    output logic [REG_W-1:0]   rs2,
    output logic [XLEN-1:0]    imm,
    output logic               rd_we,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               is_branch,
    output logic               is_jump,
    output logic               illegal
);

    imm_fmt_e        fmt_c;
    logic [XLEN-1:0] imm_c;
    ctrl_t           dec_c;

    logic            out_valid, out_valid_nxt;
    ctrl_t           out_ctrl,  out_ctrl_nxt;
    logic [XLEN-1:0] out_imm,   out_imm_nxt;
    logic [PCW-1:0]  out_pc,    out_pc_nxt;

    logic            skid_valid, skid_valid_nxt;
    ctrl_t           skid_ctrl,  skid_ctrl_nxt;
    logic [XLEN-1:0] skid_imm,   skid_imm_nxt;
    logic [PCW-1:0]  skid_pc,    skid_pc_nxt;

    logic            accept_c;
    logic            take_c;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (instr_in),
        .fmt_c (fmt_c),
        .imm_c (imm_c)
    );

    // Field split and control flags; OP is the only legal opcode without an immediate.
    always_comb begin
        dec_c         = '0;
        dec_c.opcode  = instr_in[6:0];
        dec_c.rd      = instr_in[11:7];
        dec_c.funct3  = instr_in[14:12];
        dec_c.rs1     = instr_in[19:15];
        dec_c.rs2     = instr_in[24:20];
        dec_c.funct7  = instr_in[31:25];
        dec_c.illegal = (fmt_c == IMM_NONE) && (instr_in[6:0] != OPC_OP);
        if (!dec_c.illegal) begin
            case (instr_in[6:0])
                OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP: dec_c.rd_we = 1'b1;
                OPC_JAL, OPC_JALR: begin
                    dec_c.rd_we   = 1'b1;
                    dec_c.is_jump = 1'b1;
                end
                OPC_BRANCH: dec_c.is_branch = 1'b1;
                OPC_LOAD: begin
                    dec_c.rd_we  = 1'b1;
                    dec_c.mem_rd = 1'b1;
                end
                OPC_STORE: dec_c.mem_wr = 1'b1;
                default: ;
            endcase
        end
        dec_c.rd_we = dec_c.rd_we && (dec_c.rd != '0);
    end

    assign accept_c = valid_in && !skid_valid && !flush;
    assign take_c   = out_valid && ready_in;

    // Output/skid register steering; the skid only fills while the output is stalled.
    always_comb begin
        out_valid_nxt  = out_valid;
        out_ctrl_nxt   = out_ctrl;
        out_imm_nxt    = out_imm;
        out_pc_nxt     = out_pc;
        skid_valid_nxt = skid_valid;
        skid_ctrl_nxt  = skid_ctrl;
        skid_imm_nxt   = skid_imm;
        skid_pc_nxt    = skid_pc;
        if (flush) begin
            out_valid_nxt  = 1'b0;
            skid_valid_nxt = 1'b0;
        end else if (!out_valid || take_c) begin
            if (skid_valid) begin
                out_valid_nxt  = 1'b1;
                out_ctrl_nxt   = skid_ctrl;
                out_imm_nxt    = skid_imm;
                out_pc_nxt     = skid_pc;
                skid_valid_nxt = 1'b0;
            end else if (accept_c) begin
                out_valid_nxt  = 1'b1;
                out_ctrl_nxt   = dec_c;
                out_imm_nxt    = imm_c;
                out_pc_nxt     = pc_in;
            end else begin
                out_valid_nxt  = 1'b0;
            end
        end else if (accept_c) begin
            skid_valid_nxt = 1'b1;
            skid_ctrl_nxt  = dec_c;
            skid_imm_nxt   = imm_c;
            skid_pc_nxt    = pc_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            out_imm    <= '0;
            out_pc     <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_imm   <= '0;
            skid_pc    <= '0;
        end else begin
            out_valid  <= out_valid_nxt;
            out_ctrl   <= out_ctrl_nxt;
            out_imm    <= out_imm_nxt;
            out_pc     <= out_pc_nxt;
            skid_valid <= skid_valid_nxt;
            skid_ctrl  <= skid_ctrl_nxt;
            skid_imm   <= skid_imm_nxt;
            skid_pc    <= skid_pc_nxt;
        end
    end

    assign ready_out = !skid_valid;
    assign valid_out = out_valid;
    assign pc_out    = out_pc;
    assign imm       = out_imm;
    assign opcode    = out_ctrl.opcode;
    assign funct3    = out_ctrl.funct3;
    assign funct7    = out_ctrl.funct7;
    assign rd        = out_ctrl.rd;
    assign rs1       = out_ctrl.rs1;
    assign rs2       = out_ctrl.rs2;
    assign rd_we     = out_ctrl.rd_we;
    assign mem_rd    = out_ctrl.mem_rd;
    assign mem_wr    = out_ctrl.mem_wr;
    assign is_branch = out_ctrl.is_branch;
    assign is_jump   = out_ctrl.is_jump;
    assign illegal   = out_ctrl.illegal;

endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed steps then randomized traffic against a queue model
// of accepted-but-not-yet-taken instructions.
module tb_decode;

    logic        clk;
    logic        reset;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        valid_in;
    logic        ready_out;
    logic        flush;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] pc_out;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        rd_we, mem_rd, mem_wr, is_branch, is_jump, illegal;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t q[$];

    decode #(.XLEN(32), .PCW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr_in  (instr_in),
        .pc_in     (pc_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .flush     (flush),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .pc_out    (pc_out),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .rd_we     (rd_we),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .is_branch (is_branch),
        .is_jump   (is_jump),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Immediate value from the written format rules, via signed arithmetic.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int s;
        s = $signed(i);
        case (i[6:0])
            7'b0110111, 7'b0010111: return i & 32'hFFFF_F000;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: return 32'(s >>> 20);
            7'b0100011: return 32'((s >>> 25) * 32 + int'(i[11:7]));
            7'b1100011: return 32'((s >>> 31) * 4096 + int'(i[7]) * 2048
                                   + int'(i[30:25]) * 32 + int'(i[11:8]) * 2);
            7'b1101111: return 32'((s >>> 31) * 1048576 + int'(i[19:12]) * 4096
                                   + int'(i[20]) * 2048 + int'(i[30:21]) * 2);
            default: return 32'h0;
        endcase
    endfunction

    // {rd_we, mem_rd, mem_wr, is_branch, is_jump, illegal}
    function automatic logic [5:0] ref_flags(input logic [31:0] i);
        logic w, mr, mw, br, jp, il;
        logic [6:0] o;
        o = i[6:0];
        w = 0; mr = 0; mw = 0; br = 0; jp = 0; il = 0;
        if (o == 7'b0110111 || o == 7'b0010111 || o == 7'b0010011 || o == 7'b0110011) w = 1;
        else if (o == 7'b1101111 || o == 7'b1100111) begin w = 1; jp = 1; end
        else if (o == 7'b1100011) br = 1;
        else if (o == 7'b0000011) begin w = 1; mr = 1; end
        else if (o == 7'b0100011) mw = 1;
        else if (o == 7'b1110011) ;
        else il = 1;
        if (i[11:7] == 5'd0) w = 0;
        return {w, mr, mw, br, jp, il};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] dut_flags();
        return {rd_we, mem_rd, mem_wr, is_branch, is_jump, illegal};
    endfunction

    task automatic check_all();
        chk("valid_out", 32'(valid_out), 32'(q.size() > 0));
        chk("ready_out", 32'(ready_out), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk("pc_out", pc_out, q[0].pc);
            chk("opcode", 32'(opcode), 32'(q[0].instr[6:0]));
            chk("funct3", 32'(funct3), 32'(q[0].instr[14:12]));
            chk("funct7", 32'(funct7), 32'(q[0].instr[31:25]));
            chk("rd",     32'(rd),     32'(q[0].instr[11:7]));
            chk("rs1",    32'(rs1),    32'(q[0].instr[19:15]));
            chk("rs2",    32'(rs2),    32'(q[0].instr[24:20]));
            chk("imm",    imm,         ref_imm(q[0].instr));
            chk("flags",  32'(dut_flags()), 32'(ref_flags(q[0].instr)));
        end
    endtask

    // One clock: model sees the pre-edge inputs and queue, then compares after the edge.
    task automatic step();
        bit tk, ac;
        tk = (q.size() > 0) && ready_in;
        ac = valid_in && (q.size() < 2) && !flush;
        @(posedge clk);
        #1;
        if (tk) void'(q.pop_front());
        if (flush) q.delete();
        else if (ac) q.push_back('{pc: pc_in, instr: instr_in});
        check_all();
    endtask

    task automatic offer(input logic v, input logic [31:0] i, input logic [31:0] p);
        valid_in = v;
        instr_in = i;
        pc_in    = p;
    endtask

    logic [6:0] legal_opc [10];

    initial begin
        legal_opc = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};
        reset = 1'b0; valid_in = 0; instr_in = 0; pc_in = 0; flush = 0; ready_in = 0;
        #12;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_imm", imm, 32'd0);
        chk("rst_flags", 32'(dut_flags()), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // back-to-back addi x1,x0,-1
        ready_in = 1;
        offer(1, 32'hFFF0_0093, 32'd5);
        step();
        chk("addi_imm", imm, 32'hFFFF_FFFF);
        chk("addi_rd", 32'(rd), 32'd1);
        chk("addi_we", 32'(rd_we), 32'd1);
        chk("addi_pc", pc_out, 32'd5);
        step();
        chk("addi2_valid", 32'(valid_out), 32'd1);
        offer(0, 32'h0, 32'h0);
        step();

        // stall: beq then sw, execute holds for three cycles
        ready_in = 0;
        offer(1, 32'h0000_0463, 32'd10);
        step();
        offer(1, 32'h0011_2223, 32'd11);
        step();
        chk("stall_ready", 32'(ready_out), 32'd0);
        offer(1, 32'h0010_0093, 32'd12);
        step();
        chk("beq_imm", imm, 32'd8);
        chk("beq_branch", 32'(is_branch), 32'd1);
        offer(0, 32'h0, 32'h0);
        ready_in = 1;
        step();
        chk("sw_imm", imm, 32'd4);
        chk("sw_pc", pc_out, 32'd11);
        chk("sw_memwr", 32'(mem_wr), 32'd1);
        step();
        chk("drain_valid", 32'(valid_out), 32'd0);

        // flush with both registers full and a new offer
        ready_in = 0;
        offer(1, 32'h0000_0463, 32'd20);
        step();
        offer(1, 32'h0011_2223, 32'd21);
        step();
        offer(1, 32'hFFF0_0093, 32'd22);
        flush = 1;
        step();
        chk("flush_valid", 32'(valid_out), 32'd0);
        chk("flush_ready", 32'(ready_out), 32'd1);
        flush = 0;
        offer(0, 32'h0, 32'h0);
        ready_in = 1;
        step();
        chk("postflush_valid", 32'(valid_out), 32'd0);

        // illegal encodings and rd=x0 write suppression
        offer(1, 32'h0000_007F, 32'd30);
        step();
        chk("ill7f", 32'(dut_flags()), 32'b000001);
        offer(1, 32'h0000_0000, 32'd31);
        step();
        chk("ill00", 32'(dut_flags()), 32'b000001);
        offer(1, 32'h0010_0013, 32'd32);
        step();
        chk("addi_x0_flags", 32'(dut_flags()), 32'd0);
        chk("addi_x0_imm", imm, 32'd1);
        offer(0, 32'h0, 32'h0);
        step();

        // asynchronous reset with both registers full
        ready_in = 0;
        offer(1, 32'h0000_0463, 32'd40);
        step();
        offer(1, 32'h0011_2223, 32'd41);
        step();
        #2;
        reset = 1'b0;
        q.delete();
        #1;
        chk("midrst_valid", 32'(valid_out), 32'd0);
        chk("midrst_ready", 32'(ready_out), 32'd1);
        chk("midrst_imm", imm, 32'd0);
        chk("midrst_pc", pc_out, 32'd0);
        offer(0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        ready_in = 1;
        offer(1, 32'hFFF0_0093, 32'd7);
        step();
        chk("postrst_pc", pc_out, 32'd7);
        chk("postrst_valid", 32'(valid_out), 32'd1);

        // randomized traffic
        for (int n = 0; n < 10000; n++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 9) < 8) r[6:0] = legal_opc[$urandom_range(0, 9)];
            offer(1'($urandom_range(0, 9) < 7), r, $urandom);
            ready_in = 1'($urandom_range(0, 9) < 6);
            flush    = 1'($urandom_range(0, 11) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode.md
# decode

Decode stage of the PikaRISC RV32I pipeline, directly downstream of `fetch`. It accepts the byte-swapped 32-bit instruction and its PC from fetch and splits the instruction into register indices, a sign-extended immediate and control flags. The result is registered toward execute through a valid/ready pipeline register with a one-entry skid buffer, so fetch never has to drop an instruction when execute stalls. A flush input from execute, driven on a taken branch, discards everything in flight.

## Interface
Parameters:
- `XLEN`, 32: data/immediate width.
- `PCW`, 32: PC width; the PC is word-addressed and passed through unchanged.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; all state is cleared while low.
- `instr_in`  in  32  instruction from fetch (already big-endian).
- `pc_in`  in  PCW  PC of `instr_in`.
- `valid_in`  in  1  fetch presents an instruction.
- `ready_out`  out  1  decode can accept; equals `!skid_valid`.
- `flush`  in  1  from execute (taken); kills all held and incoming instructions.
- `valid_out`  out  1  decoded bundle valid.
- `ready_in`  in  1  execute accepts the bundle this cycle.
- `pc_out`  out  PCW  PC of the bundle.
- `opcode`  out  7  instr[6:0].
- `funct3`  out  3  instr[14:12].
- `funct7`  out  7  instr[31:25].
- `rd`, `rs1`, `rs2`  out  5 each  register indices.
- `imm`  out  XLEN  sign-extended immediate; format is selected by opcode.
- `rd_we`, `mem_rd`, `mem_wr`, `is_branch`, `is_jump`, `illegal`  out  1 each  control flags.

## Operation
- Acceptance: an instruction is accepted at a rising edge where `valid_in && ready_out && !flush`.
- Field decode is combinational from `instr_in`, and the result is captured into the output register or into the skid register.
- Opcode classes and their flags:
  - LUI 0110111 and AUIPC 0010111: U-format; `rd_we`=1.
  - JAL 1101111: J-format; `rd_we`=1, `is_jump`=1.
  - JALR 1100111: I-format; `rd_we`=1, `is_jump`=1.
  - BRANCH 1100011: B-format; `is_branch`=1.
  - LOAD 0000011: I-format; `rd_we`=1, `mem_rd`=1.
  - STORE 0100011: S-format; `mem_wr`=1.
  - OP-IMM 0010011: I-format; `rd_we`=1.
  - OP 0110011: `imm`=0; `rd_we`=1.
  - SYSTEM 1110011: I-format; no flags set.
- Immediate formats, all sign-extended from instr[31]:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- Illegal instructions: any other opcode, or instr[1:0]≠2'b11, sets `illegal`=1 and clears every other control flag. Fields still pass through.
- `rd_we` is forced to 0 when `rd`=0.
- Skid buffer:
  - If `valid_out && !ready_in` and an instruction is accepted, the new bundle goes into the skid register and `ready_out` drops the next cycle.
  - When execute takes the output bundle (`valid_out && ready_in`), a full skid register moves to the output and empties.
  - When execute takes the output bundle and the skid register is empty, the output loads the newly accepted bundle, or `valid_out` drops if nothing was accepted.
- Ordering: bundles leave in acceptance order; none is duplicated or lost except by flush.

## Timing
- Reset: `valid_out`=0, skid empty, so `ready_out`=1. All data outputs and flags are 0.
- Reset is asynchronous and takes effect mid-transfer; there is no partial bundle after release.
- Latency: an instruction accepted at edge N appears with `valid_out`=1 after edge N; one cycle.
- Throughput: one instruction per cycle while `ready_in`=1.
- `ready_out` is registered-derived; it has no combinational path from `ready_in`.
- Output data is held stable while `valid_out && !ready_in`.
- Flush at edge N: `valid_out`=0 and skid empty after N. A same-cycle `valid_in` is dropped, and a same-cycle `ready_in` transfer still counts as taken by execute.
- Both registers full and `ready_in`=0: `ready_out`=0 and state is held.

## Structure
- Shared package `pika_pkg` holds the opcode localparams (OPC_LUI … OPC_SYSTEM) and the immediate-format enum (IMM_I/S/B/U/J/NONE).
- One sub-module, `imm_gen`: combinational instruction → {format, imm}, shared with any later compressed-instruction decoder.
- The skid/output register pair stays inline in `decode`.

## Test plan
- Reset low mid-stream → `valid_out`=0, `ready_out`=1, `imm`=0; first instruction after release appears one cycle later.
- Back-to-back `addi x1,x0,-1` (0xFFF00093), pc 5, with `ready_in`=1 → `rd`=1, `imm`=0xFFFFFFFF, `rd_we`=1, `pc_out`=5 one cycle after acceptance.
- Hold `ready_in`=0 for 3 cycles while fetch offers `beq` 0x00000463 then `sw` 0x00112223 → `ready_out`=0 after the second accept; release gives B-imm 8 then S-imm 4 in order, with no loss.
- `flush`=1 with both registers full and `valid_in`=1 → next cycle `valid_out`=0, `ready_out`=1; the flushed instructions never appear.
- Opcode 0x7F and instruction 0x00000000 → `illegal`=1 with all other flags 0; `addi x0,x0,1` → `rd_we`=0.
- Random valid/ready/flush for 10k cycles against a reference queue model → in-order, lossless and duplicate-free except for flushed entries.
